instruction_mem_rom: RTL and testbench
======================================

// Module: instruction_mem_rom
// PURPOSE
//  - Word-organised instruction memory for the 16-bit MIPS datapath; fetch stage drives byte address, gets 16-bit instruction.
//  - Asynchronous (combinational) read; synchronous load port for program download; async reset restores the default image.
//  - Default image: word i holds value i, so byte address 0x0060 -> 48, 0x0050 -> 40.
// PARAMETERS
//  - ADDR_W      16   byte-address width of address / load_addr
//  - DATA_W      16   instruction word width
//  - DEPTH_WORDS 256  number of instruction words; index = address[ADDR_W-1:1]
// PORTS
//  - clk          in   1       single clock; load writes on rising edge
//  - rst          in   1       asynchronous, active-high reset
//  - address      in   ADDR_W  fetch byte address
//  - instruction  out  DATA_W  instruction word at address (combinational)
//  - load_en      in   1       write enable for program load
//  - load_addr    in   ADDR_W  byte address of word to load
//  - load_data    in   DATA_W  word to store
//  - fault        out  1       only when INSTR_MEM_FAULT_EN defined (see CONFIGURATION)
// BEHAVIOUR
//  - One clock (clk); rst asynchronous, active-high; no other clocks or resets.
//  - Word index = address >> 1; address[0] ignored (fetch always word-aligned).
//  - Read: instruction = mem[address>>1]; purely combinational, zero-cycle latency, settles within same delta/propagation.
//  - Out of range (index >= DEPTH_WORDS): instruction = 16'h0000 (NOP); no wrap-around.
//  - Reset (rst=1, asynchronous assert): every mem[i] <= i[DATA_W-1:0] immediately; held while rst=1; load ignored during reset.
//  - Reset output value: instruction = default image word for current address (e.g. address 0x0000 -> 0x0000).
//  - Load: on posedge clk with rst=0 and load_en=1, mem[load_addr>>1] <= load_data; load_addr[0] ignored.
//  - Out-of-range load: dropped silently, memory unchanged.
//  - Read/load same word: instruction shows old value until the clk edge, new value right after (no bypass).
//  - Reset asserted mid-load: reset wins; the word ends with its default value.
//  - No handshake; no state machine; memory content is the only state.
// CONFIGURATION
//  - Macro INSTR_MEM_FAULT_EN:
//  - defined: output fault = 1 combinationally when address[0]=1 or address index >= DEPTH_WORDS, else 0.
//  - defined: fault = 0 during reset unless address itself is faulty (purely combinational on address).
//  - defined: instruction still follows the normal read rules.
//  - not defined: port fault does not exist; misaligned/out-of-range handled silently as above.
// TESTING
//  - rst pulse, address=16'h0060, wait 500 ns -> instruction == 48.
//  - address=16'h0050, wait 500 ns -> instruction == 40; address=16'h0051 -> 40 (fault=1 if INSTR_MEM_FAULT_EN).
//  - load_en=1, load_addr=16'h0060, load_data=16'hBEEF, one clk edge -> address 0x0060 reads 16'hBEEF; 0x0050 still 40.
//  - after load above, assert rst asynchronously (no clk) -> address 0x0060 reads 48 again.
//  - address=16'h0200 (index 256, DEPTH_WORDS=256) -> instruction 16'h0000; load there then read -> still 0.
//  - load_en=1 with rst=1 across clk edge, load_addr=0x0010, data=16'h1234 -> address 0x0010 reads 8.

Source files
------------

// File: rtl/instruction_mem_rom.sv
// Word-organised instruction memory: combinational fetch, clocked program load, async reset to identity image.
// Optional INSTR_MEM_FAULT_EN adds a combinational fault output for misaligned or out-of-range fetches.
module instruction_mem_rom #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int DEPTH_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instruction,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
`ifdef INSTR_MEM_FAULT_EN
  ,
  output logic              fault
`endif
);

  localparam int IDX_W = ADDR_W - 1;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  logic [IDX_W-1:0] w_rdIdx;
  logic [IDX_W-1:0] w_ldIdx;
  logic             w_rdInRange;
  logic             w_ldInRange;
  logic             w_unused;

  // Byte address bit 0 never selects anything; word index is the upper bits.
  assign w_rdIdx     = address[ADDR_W-1:1];
  assign w_ldIdx     = load_addr[ADDR_W-1:1];
  assign w_rdInRange = (32'(w_rdIdx) < DEPTH_WORDS);
  assign w_ldInRange = (32'(w_ldIdx) < DEPTH_WORDS);
  assign w_unused    = load_addr[0];

  assign instruction = w_rdInRange ? r_mem[w_rdIdx[MEM_AW-1:0]] : '0;

`ifdef INSTR_MEM_FAULT_EN
  assign fault = address[0] | ~w_rdInRange;
`else
  logic w_unusedAlign;
  assign w_unusedAlign = address[0];
`endif

  // Reset reloads the identity image; out-of-range loads are silently dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= DATA_W'(i);
      end
    end else if (load_en && w_ldInRange) begin
      r_mem[w_ldIdx[MEM_AW-1:0]] <= load_data;
    end
  end

endmodule

// File: tb/tb_instruction_mem_rom.sv
// Self-checking bench for instruction_mem_rom: vector table plus hand-written load/reset sequences.
// Expected values are queued when stimulus is applied and popped when the output is sampled.
module tb_instruction_mem_rom;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] instruction;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
`ifdef INSTR_MEM_FAULT_EN
  logic              fault;
`endif

  always #5 clk = ~clk;

  instruction_mem_rom #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH_WORDS(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .address(address),
    .instruction(instruction),
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data)
`ifdef INSTR_MEM_FAULT_EN
    ,
    .fault(fault)
`endif
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] expInstr;
    string             name;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] expInstr;
    logic              expFault;
    string             name;
  } exp_t;

  exp_t sbQueue[$];
  int   nChecks = 0;
  int   nErrors = 0;

  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] expInstr,
                               input string name);
    exp_t e;
    address    = addr;
    e.expInstr = expInstr;
    e.expFault = addr[0] || (addr[ADDR_W-1:1] >= 15'(DEPTH));
    e.name     = name;
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    #1;
    if (sbQueue.size() == 0) begin
      nChecks++;
      nErrors++;
      $display("[TB] FAIL scoreboard_empty: no expected value queued at %0t", $time);
      return;
    end
    e = sbQueue.pop_front();
    nChecks++;
    if (instruction !== e.expInstr) begin
      nErrors++;
      $display("[TB] FAIL %s: instruction got %h expected %h", e.name, instruction, e.expInstr);
    end
`ifdef INSTR_MEM_FAULT_EN
    nChecks++;
    if (fault !== e.expFault) begin
      nErrors++;
      $display("[TB] FAIL %s_fault: fault got %b expected %b", e.name, fault, e.expFault);
    end
`endif
  endtask

  task automatic loadWord(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    @(posedge clk);
    #1;
    load_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    logic [ADDR_W-1:0] rAddr;
    logic [DATA_W-1:0] rExp;

    vecs[0] = '{16'h0060, 16'd48,   "default_0x60"};
    vecs[1] = '{16'h0050, 16'd40,   "default_0x50"};
    vecs[2] = '{16'h0051, 16'd40,   "misaligned_0x51"};
    vecs[3] = '{16'h0000, 16'd0,    "first_word"};
    vecs[4] = '{16'h0002, 16'd1,    "second_word"};
    vecs[5] = '{16'h01FE, 16'd255,  "last_word"};
    vecs[6] = '{16'h01FF, 16'd255,  "last_word_odd"};
    vecs[7] = '{16'h0200, 16'h0000, "first_out_of_range"};
    vecs[8] = '{16'hFFFE, 16'h0000, "top_out_of_range"};
    vecs[9] = '{16'h0101, 16'd128,  "mid_odd"};

    rst       = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    address   = '0;

    #2;
    applyStimulus(16'h0000, 16'h0000, "reset_addr0");
    checkOutput();
    applyStimulus(16'h0060, 16'd48, "reset_0x60");
    checkOutput();

    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].addr, vecs[i].expInstr, vecs[i].name);
      checkOutput();
    end

    // Same-word read while a load is pending shows the old value until the edge.
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = 16'h0060;
    load_data = 16'hBEEF;
    applyStimulus(16'h0060, 16'd48, "no_bypass_before_edge");
    checkOutput();
    @(posedge clk);
    applyStimulus(16'h0060, 16'hBEEF, "load_after_edge");
    checkOutput();
    load_en = 1'b0;
    applyStimulus(16'h0050, 16'd40, "neighbour_unchanged");
    checkOutput();

    loadWord(16'h0071, 16'hCAFE);
    @(negedge clk);
    applyStimulus(16'h0070, 16'hCAFE, "odd_load_addr_even_read");
    checkOutput();
    applyStimulus(16'h0071, 16'hCAFE, "odd_load_addr_odd_read");
    checkOutput();

    // Asynchronous reset between clock edges restores the default image.
    @(negedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(16'h0060, 16'd48, "async_reset_restores_0x60");
    checkOutput();
    applyStimulus(16'h0070, 16'd56, "async_reset_restores_0x70");
    checkOutput();
    @(negedge clk);
    rst = 1'b0;

    loadWord(16'h0200, 16'h5555);
    @(negedge clk);
    applyStimulus(16'h0200, 16'h0000, "oor_load_dropped");
    checkOutput();
    applyStimulus(16'h0000, 16'h0000, "oor_load_no_wrap");
    checkOutput();

    @(negedge clk);
    rst       = 1'b1;
    load_en   = 1'b1;
    load_addr = 16'h0010;
    load_data = 16'h1234;
    @(posedge clk);
    applyStimulus(16'h0010, 16'd8, "reset_beats_load_during");
    checkOutput();
    @(negedge clk);
    rst     = 1'b0;
    load_en = 1'b0;
    applyStimulus(16'h0010, 16'd8, "reset_beats_load_after");
    checkOutput();

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rAddr = 16'($urandom_range(0, 16'h03FF));
      rExp  = (rAddr[ADDR_W-1:1] < 15'(DEPTH)) ? 16'(rAddr[ADDR_W-1:1]) : 16'h0000;
      applyStimulus(rAddr, rExp, "random_default_read");
      checkOutput();
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
